// File: rtl/video_rgb_format_converter_pkg.sv
// Shared definitions for the RGB format converter: pixel modes, register map
// and the layout of the control and capability words.
package video_rgb_format_converter_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565    = 2'd0,
    MODE_RGB888    = 2'd1,
    MODE_ARGB8888  = 2'd2,
    MODE_RGB101010 = 2'd3
  } mode_e;

  localparam logic [1:0] REG_CONTROL     = 2'd0;
  localparam logic [1:0] REG_ALPHA       = 2'd1;
  localparam logic [1:0] REG_FRAME_COUNT = 2'd2;
  localparam logic [1:0] REG_CAPABILITY  = 2'd3;

  // mode_req in [1:0], active_mode in [9:8]
  function automatic logic [31:0] control_word(input mode_e req, input mode_e active);
    control_word = {22'b0, active, 6'b0, req};
  endfunction

  // channel width in [31:24], alpha-present flag in bit 23
  function automatic logic [31:0] capability_word(input int unsigned cw, input logic out_alpha);
    capability_word = {8'(cw), out_alpha, 23'b0};
  endfunction

endpackage

// File: rtl/video_channel_scaler.sv
// Rescales one colour channel from SW to CW bits: truncates when narrowing,
// left-justifies and refills LSBs with the repeating source MSBs when widening.
module video_channel_scaler #(
  parameter int unsigned SW = 8,
  parameter int unsigned CW = 10
) (
  input  logic [SW-1:0] src,
  output logic [CW-1:0] chan_c
);

  // Bit i below the output MSB takes source bit (i mod SW) below the source MSB.
  for (genvar i = 0; i < CW; i++) begin : g_bit
    assign chan_c[CW-1-i] = src[SW-1-(i%SW)];
  end

endmodule

// File: rtl/video_rgb_format_converter.sv
// Packed RGB/ARGB pixel to per-channel converter with a two-stage registered
// pipeline, packet-boundary mode switching and an Avalon-MM register slave.
module video_rgb_format_converter
  import video_rgb_format_converter_pkg::*;
#(
  parameter int unsigned CW        = 10,
  parameter int unsigned OUT_ALPHA = 1,
  parameter int unsigned EW        = 1,
  parameter logic [1:0]  DEF_MODE  = 2'd0,
  parameter logic [CW-1:0] DEF_ALPHA = {CW{1'b1}},
  localparam int unsigned ODW      = (3 + OUT_ALPHA) * CW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [31:0]    stream_in_data,
  input  logic           stream_in_startofpacket,
  input  logic           stream_in_endofpacket,
  input  logic [EW-1:0]  stream_in_empty,
  input  logic           stream_in_valid,
  output logic           stream_in_ready,
  input  logic [1:0]     slave_address,
  input  logic           slave_read,
  input  logic           slave_write,
  input  logic [31:0]    slave_writedata,
  output logic [31:0]    slave_readdata,
  input  logic           stream_out_ready,
  output logic [ODW-1:0] stream_out_data,
  output logic           stream_out_startofpacket,
  output logic           stream_out_endofpacket,
  output logic [EW-1:0]  stream_out_empty,
  output logic           stream_out_valid
);

  mode_e         mode_req, active_mode;
  logic [CW-1:0] alpha_reg;
  logic [31:0]   frame_count;

  logic          s1_valid, s1_sop, s1_eop;
  logic [EW-1:0] s1_empty;
  logic [31:0]   s1_data;
  mode_e         s1_mode;
  logic [CW-1:0] s1_alpha;

  logic s1_load, s2_load, in_accept, sop_accept;

  assign s2_load         = ~stream_out_valid | stream_out_ready;
  assign s1_load         = ~s1_valid | s2_load;
  assign stream_in_ready = s1_load;
  assign in_accept       = stream_in_valid & s1_load;
  assign sop_accept      = in_accept & stream_in_startofpacket;

  // Configuration, status and readback
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_req       <= mode_e'(DEF_MODE);
      active_mode    <= mode_e'(DEF_MODE);
      alpha_reg      <= DEF_ALPHA;
      frame_count    <= '0;
      slave_readdata <= '0;
    end else begin
      if (slave_write && slave_address == REG_CONTROL) mode_req <= mode_e'(slave_writedata[1:0]);
      if (slave_write && slave_address == REG_ALPHA) alpha_reg <= slave_writedata[CW-1:0];
      if (sop_accept) active_mode <= mode_req;
      if (slave_write && slave_address == REG_FRAME_COUNT) frame_count <= '0;
      else if (sop_accept) frame_count <= frame_count + 32'd1;
      if (slave_read) begin
        case (slave_address)
          REG_CONTROL:     slave_readdata <= control_word(mode_req, active_mode);
          REG_ALPHA:       slave_readdata <= 32'(alpha_reg);
          REG_FRAME_COUNT: slave_readdata <= frame_count;
          default:         slave_readdata <= capability_word(CW, OUT_ALPHA != 0);
        endcase
      end
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^slave_writedata[31:CW];

  // Channel scalers for every source width in use
  logic [CW-1:0] r5_c, g6_c, b5_c, r8_c, g8_c, b8_c, a8_c, r10_c, g10_c, b10_c;

  video_channel_scaler #(.SW(5),  .CW(CW)) u_r5  (.src(s1_data[15:11]), .chan_c(r5_c));
  video_channel_scaler #(.SW(6),  .CW(CW)) u_g6  (.src(s1_data[10:5]),  .chan_c(g6_c));
  video_channel_scaler #(.SW(5),  .CW(CW)) u_b5  (.src(s1_data[4:0]),   .chan_c(b5_c));
  video_channel_scaler #(.SW(8),  .CW(CW)) u_r8  (.src(s1_data[23:16]), .chan_c(r8_c));
  video_channel_scaler #(.SW(8),  .CW(CW)) u_g8  (.src(s1_data[15:8]),  .chan_c(g8_c));
  video_channel_scaler #(.SW(8),  .CW(CW)) u_b8  (.src(s1_data[7:0]),   .chan_c(b8_c));
  video_channel_scaler #(.SW(8),  .CW(CW)) u_a8  (.src(s1_data[31:24]), .chan_c(a8_c));
  video_channel_scaler #(.SW(10), .CW(CW)) u_r10 (.src(s1_data[29:20]), .chan_c(r10_c));
  video_channel_scaler #(.SW(10), .CW(CW)) u_g10 (.src(s1_data[19:10]), .chan_c(g10_c));
  video_channel_scaler #(.SW(10), .CW(CW)) u_b10 (.src(s1_data[9:0]),   .chan_c(b10_c));

  logic [CW-1:0]  r_c, g_c, b_c, a_c;
  logic [ODW-1:0] pix_c;

  always_comb begin
    r_c = r5_c;
    g_c = g6_c;
    b_c = b5_c;
    a_c = s1_alpha;
    case (s1_mode)
      MODE_RGB565:    ;
      MODE_RGB888:    begin r_c = r8_c;  g_c = g8_c;  b_c = b8_c;  end
      MODE_ARGB8888:  begin r_c = r8_c;  g_c = g8_c;  b_c = b8_c;  a_c = a8_c; end
      MODE_RGB101010: begin r_c = r10_c; g_c = g10_c; b_c = b10_c; end
    endcase
  end

  if (OUT_ALPHA != 0) begin : g_alpha
    assign pix_c = {a_c, r_c, g_c, b_c};
  end else begin : g_no_alpha
    logic unused_alpha;
    assign pix_c        = {r_c, g_c, b_c};
    assign unused_alpha = ^a_c;
  end

  // Stage 1 holds the raw beat with its mode/alpha; stage 2 holds the converted pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid                 <= 1'b0;
      s1_sop                   <= 1'b0;
      s1_eop                   <= 1'b0;
      s1_empty                 <= '0;
      s1_data                  <= '0;
      s1_mode                  <= mode_e'(DEF_MODE);
      s1_alpha                 <= DEF_ALPHA;
      stream_out_valid         <= 1'b0;
      stream_out_data          <= '0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_empty         <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= stream_in_valid;
        if (stream_in_valid) begin
          s1_data  <= stream_in_data;
          s1_sop   <= stream_in_startofpacket;
          s1_eop   <= stream_in_endofpacket;
          s1_empty <= stream_in_empty;
          s1_mode  <= stream_in_startofpacket ? mode_req : active_mode;
          s1_alpha <= alpha_reg;
        end
      end
      if (s2_load) begin
        stream_out_valid <= s1_valid;
        if (s1_valid) begin
          stream_out_data          <= pix_c;
          stream_out_startofpacket <= s1_sop;
          stream_out_endofpacket   <= s1_eop;
          stream_out_empty         <= s1_empty;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_rgb_format_converter.sv
// Directed self-checking bench for video_rgb_format_converter (CW=10, alpha output).
module tb_video_rgb_format_converter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] stream_in_data;
  logic        stream_in_startofpacket, stream_in_endofpacket;
  logic [0:0]  stream_in_empty;
  logic        stream_in_valid, stream_in_ready;
  logic [1:0]  slave_address;
  logic        slave_read, slave_write;
  logic [31:0] slave_writedata, slave_readdata;
  logic        stream_out_ready;
  logic [39:0] stream_out_data;
  logic        stream_out_startofpacket, stream_out_endofpacket;
  logic [0:0]  stream_out_empty;
  logic        stream_out_valid;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  video_rgb_format_converter #(
    .CW(10), .OUT_ALPHA(1), .EW(1), .DEF_MODE(2'd0), .DEF_ALPHA(10'h3FF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .stream_in_data(stream_in_data),
    .stream_in_startofpacket(stream_in_startofpacket),
    .stream_in_endofpacket(stream_in_endofpacket),
    .stream_in_empty(stream_in_empty),
    .stream_in_valid(stream_in_valid),
    .stream_in_ready(stream_in_ready),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .stream_out_ready(stream_out_ready),
    .stream_out_data(stream_out_data),
    .stream_out_startofpacket(stream_out_startofpacket),
    .stream_out_endofpacket(stream_out_endofpacket),
    .stream_out_empty(stream_out_empty),
    .stream_out_valid(stream_out_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic bus_read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    chk(tag, 64'(slave_readdata), 64'(exp));
  endtask

  // Presents one beat and returns on the falling edge after it was accepted.
  task automatic send(input logic [31:0] d, input logic sop, input logic eop);
    int n;
    @(negedge clk);
    stream_in_data = d; stream_in_startofpacket = sop; stream_in_endofpacket = eop;
    stream_in_valid = 1'b1;
    n = 0;
    while (!stream_in_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk("send_timeout", 64'(stream_in_ready), 64'd1);
    @(negedge clk);
    stream_in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [39:0] exp, input logic sop, input logic eop);
    int n;
    n = 0;
    while (!stream_out_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 64'(stream_out_valid), 64'd1);
    chk({tag, "_data"}, 64'(stream_out_data), 64'(exp));
    chk({tag, "_framing"}, 64'({stream_out_startofpacket, stream_out_endofpacket}), 64'({sop, eop}));
  endtask

  function automatic logic [31:0] rnd_beat(input int k);
    return 32'(k) * 32'h0123_4567 + 32'h2A5A_5A5A;
  endfunction

  int          tx, rx;
  logic        stalled;
  logic [39:0] held_data;
  logic [1:0]  held_frm;
  logic [31:0] b;

  initial begin
    reset_n = 1'b0;
    stream_in_data = '0; stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b0;
    stream_in_empty = '0; stream_in_valid = 1'b0;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    stream_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(stream_out_valid), 64'd0);
    chk("rst_out_data", 64'(stream_out_data), 64'd0);
    chk("rst_readdata", 64'(slave_readdata), 64'd0);
    reset_n = 1'b1;

    bus_read_chk("rst_ctrl", 2'd0, 32'h0000_0000);
    bus_read_chk("rst_alpha", 2'd1, 32'h0000_03FF);
    bus_read_chk("rst_fcount", 2'd2, 32'h0000_0000);
    bus_read_chk("capability", 2'd3, 32'h0A80_0000);

    // RGB565 red with 2-cycle latency
    send(32'h0000_F800, 1'b1, 1'b1);
    chk("lat_stage1", 64'(stream_out_valid), 64'd0);
    @(negedge clk);
    chk("lat_stage2", 64'(stream_out_valid), 64'd1);
    chk("m0_red", 64'(stream_out_data), 64'({10'h3FF, 10'h3FF, 10'h000, 10'h000}));

    bus_write(2'd0, 32'd1);
    send(32'h0012_3456, 1'b1, 1'b1);
    expect_out("m1", {10'h3FF, 10'h048, 10'h0D0, 10'h159}, 1'b1, 1'b1);
    bus_read_chk("ctrl_m1", 2'd0, 32'h0000_0101);

    bus_write(2'd0, 32'd2);
    send(32'h8012_3456, 1'b1, 1'b1);
    expect_out("m2", {10'h202, 10'h048, 10'h0D0, 10'h159}, 1'b1, 1'b1);

    // Mode request changed mid-packet only applies from the next SOP
    bus_write(2'd0, 32'd0);
    send(32'h0000_001F, 1'b1, 1'b0);
    expect_out("sw_b0", {10'h3FF, 10'h000, 10'h000, 10'h3FF}, 1'b1, 1'b0);
    bus_write(2'd0, 32'd1);
    send(32'h0000_07E0, 1'b0, 1'b1);
    expect_out("sw_b1", {10'h3FF, 10'h000, 10'h3FF, 10'h000}, 1'b0, 1'b1);
    bus_read_chk("ctrl_pending", 2'd0, 32'h0000_0001);
    send(32'h0012_3456, 1'b1, 1'b1);
    expect_out("sw_next", {10'h3FF, 10'h048, 10'h0D0, 10'h159}, 1'b1, 1'b1);
    bus_read_chk("ctrl_latched", 2'd0, 32'h0000_0101);

    // RGB101010 packet under random backpressure
    bus_write(2'd0, 32'd3);
    bus_write(2'd1, 32'h155);
    bus_write(2'd2, 32'd0);
    bus_read_chk("fcount_clr", 2'd2, 32'd0);
    tx = 0; rx = 0; stalled = 1'b0; held_data = '0; held_frm = '0;
    for (int cyc = 0; cyc < 500 && rx < 16; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("hold_valid", 64'(stream_out_valid), 64'd1);
        chk("hold_data", 64'(stream_out_data), 64'(held_data));
        chk("hold_framing", 64'({stream_out_startofpacket, stream_out_endofpacket}), 64'(held_frm));
      end
      stream_out_ready        = 1'($urandom_range(0, 1));
      stream_in_valid         = (tx < 16);
      stream_in_data          = rnd_beat(tx);
      stream_in_startofpacket = (tx == 0);
      stream_in_endofpacket   = (tx == 15);
      stream_in_empty         = 1'(tx);
      #1;
      chk("in_ready", 64'(stream_in_ready), 64'(!((tx - rx) == 2 && !stream_out_ready)));
      if (stream_out_valid && stream_out_ready) begin
        b = rnd_beat(rx);
        chk("bp_data", 64'(stream_out_data), 64'({10'h155, b[29:0]}));
        chk("bp_framing", 64'({stream_out_startofpacket, stream_out_endofpacket, stream_out_empty}),
            64'({rx == 0, rx == 15, 1'(rx)}));
        rx++;
      end
      if (stream_in_valid && stream_in_ready) tx++;
      stalled   = stream_out_valid && !stream_out_ready;
      held_data = stream_out_data;
      held_frm  = {stream_out_startofpacket, stream_out_endofpacket};
    end
    chk("bp_count", 64'(rx), 64'd16);
    @(negedge clk);
    stream_in_valid = 1'b0; stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b0;
    stream_in_empty = '0; stream_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_no_extra", 64'(stream_out_valid), 64'd0);

    send(32'h3FF0_0001, 1'b1, 1'b1);
    expect_out("m3_a", {10'h155, 10'h3FF, 10'h000, 10'h001}, 1'b1, 1'b1);
    send(32'h0000_0000, 1'b1, 1'b1);
    expect_out("m3_b", {10'h155, 10'h000, 10'h000, 10'h000}, 1'b1, 1'b1);
    bus_read_chk("fcount_3", 2'd2, 32'd3);

    // Simultaneous read and write returns the old value
    @(negedge clk);
    slave_address = 2'd1; slave_writedata = 32'h0AA; slave_write = 1'b1; slave_read = 1'b1;
    @(negedge clk);
    slave_write = 1'b0; slave_read = 1'b0;
    chk("rw_same_cycle", 64'(slave_readdata), 64'h155);
    bus_read_chk("alpha_new", 2'd1, 32'h0AA);

    // Reset in the middle of a stalled packet
    bus_write(2'd0, 32'd2);
    stream_out_ready = 1'b0;
    send(32'h8012_3456, 1'b1, 1'b0);
    send(32'h8012_3456, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(stream_out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(stream_out_valid), 64'd0);
    chk("midrst_data", 64'(stream_out_data), 64'd0);
    chk("midrst_readdata", 64'(slave_readdata), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stream_out_ready = 1'b1;
    bus_read_chk("post_ctrl", 2'd0, 32'h0000_0000);
    bus_read_chk("post_alpha", 2'd1, 32'h0000_03FF);
    bus_read_chk("post_fcount", 2'd2, 32'd0);
    bus_write(2'd0, 32'd1);
    send(32'h0000_F800, 1'b0, 1'b1);
    expect_out("post_nosop", {10'h3FF, 10'h3FF, 10'h000, 10'h000}, 1'b0, 1'b1);
    bus_read_chk("post_ctrl2", 2'd0, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
